// File: rtl/diila_trig_seq.sv
// Multi-stage trigger sequencer feeding the logic analyzer core: up to four
// masked/edge match stages with occurrence counts, a storage qualifier and a
// one-cycle aligned pass-through of probe data, configured over Wishbone.
module diila_trig_seq #(
    parameter int DATA_WIDTH = 96
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [23:2]           wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    input  logic [31:0]           cmp_i,
    input  logic                  storage_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [31:0]           trig_o,
    output logic                  storage_en_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  stage_q, stage_d;
    logic [15:0] occ_q, occ_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] prev_q;

    logic [1:0]  ctrl_last;
    logic [31:0] qmask, qval;
    logic        qen;
    logic [31:0] stg_mask [4];
    logic [31:0] stg_val  [4];
    logic [31:0] stg_edge [4];
    logic [15:0] stg_cnt  [4];

    logic [5:0] word_adr;
    logic [5:0] stg_off;
    logic [1:0] stg_idx, stg_fld;
    logic       is_stg;
    logic       wr_en, ctrl_wr, arm_req, abort_req;

    assign word_adr  = wb_adr_i[7:2];
    assign stg_off   = word_adr - 6'd8;
    assign stg_idx   = stg_off[3:2];
    assign stg_fld   = stg_off[1:0];
    assign is_stg    = (word_adr >= 6'd8) && (word_adr < 6'd24);
    assign wr_en     = wb_cyc_i & wb_stb_i & wb_we_i;
    assign ctrl_wr   = wr_en && (word_adr == 6'h00);
    assign arm_req   = ctrl_wr & wb_dat_i[0];
    assign abort_req = ctrl_wr & wb_dat_i[1];

    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[23:8], stg_off[5:4]};

    // Configuration registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_last <= 2'd0;
            qmask     <= '0;
            qval      <= '0;
            qen       <= 1'b0;
            // NOTE: the stage tables are plain flops, not RAM, so they are
            // reset explicitly; a reset loop like this would not map onto a
            // memory macro.
            for (int i = 0; i < 4; i++) begin
                stg_mask[i] <= '0;
                stg_val[i]  <= '0;
                stg_edge[i] <= '0;
                stg_cnt[i]  <= '0;
            end
        end else if (wr_en) begin
            if (word_adr == 6'h00) begin
                ctrl_last <= wb_dat_i[5:4];
            end else if (word_adr == 6'h02) begin
                qmask <= wb_dat_i;
            end else if (word_adr == 6'h03) begin
                qval <= wb_dat_i;
            end else if (word_adr == 6'h04) begin
                qen <= wb_dat_i[0];
            end else if (is_stg) begin
                case (stg_fld)
                    2'd0:    stg_mask[stg_idx] <= wb_dat_i;
                    2'd1:    stg_val[stg_idx]  <= wb_dat_i;
                    2'd2:    stg_edge[stg_idx] <= wb_dat_i;
                    default: stg_cnt[stg_idx]  <= wb_dat_i[15:0];
                endcase
            end
        end
    end

    // Combinational read mux
    always_comb begin
        wb_dat_o = '0;
        case (word_adr)
            6'h00: wb_dat_o = {26'b0, ctrl_last, 4'b0};
            6'h01: wb_dat_o = {occ_q, 10'b0, stage_q, 2'b00,
                               state_q == S_FIRED, state_q == S_ARMED};
            6'h02: wb_dat_o = qmask;
            6'h03: wb_dat_o = qval;
            6'h04: wb_dat_o = {31'b0, qen};
            default: begin
                if (is_stg) begin
                    case (stg_fld)
                        2'd0:    wb_dat_o = stg_mask[stg_idx];
                        2'd1:    wb_dat_o = stg_val[stg_idx];
                        2'd2:    wb_dat_o = stg_edge[stg_idx];
                        default: wb_dat_o = {16'b0, stg_cnt[stg_idx]};
                    endcase
                end
            end
        endcase
    end

    // Only the current stage is evaluated each cycle.
    logic [31:0] rise;
    logic        hit, more_needed, qual, fire;
    logic [16:0] cnt_eff;

    assign rise        = cmp_i & ~prev_q;
    assign hit         = (((cmp_i ^ stg_val[stage_q]) & stg_mask[stage_q]) == 32'd0)
                         && ((rise & stg_edge[stage_q]) == stg_edge[stage_q]);
    assign cnt_eff     = (stg_cnt[stage_q] == 16'd0) ? 17'd1 : {1'b0, stg_cnt[stage_q]};
    assign more_needed = ({1'b0, occ_q} + 17'd1) < cnt_eff;
    assign qual        = !qen || (((cmp_i ^ qval) & qmask) == 32'd0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        stage_d = stage_q;
        occ_d   = occ_q;
        last_d  = last_q;
        if (abort_req) begin
            state_d = S_IDLE;
        end else if (arm_req) begin
            state_d = S_ARMED;
            stage_d = 2'd0;
            occ_d   = 16'd0;
            last_d  = wb_dat_i[5:4];
        end else if (state_q == S_ARMED && hit) begin
            if (more_needed) begin
                occ_d = occ_q + 16'd1;
            end else if (stage_q == last_q) begin
                state_d = S_FIRED;
            end else begin
                stage_d = stage_q + 2'd1;
                occ_d   = 16'd0;
            end
        end
    end

    assign fire = (state_q == S_ARMED) && (state_d == S_FIRED);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            stage_q      <= 2'd0;
            occ_q        <= 16'd0;
            last_q       <= 2'd0;
            prev_q       <= '0;
            wb_ack_o     <= 1'b0;
            trig_o       <= '0;
            storage_en_o <= 1'b0;
            data_o       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop samples
            // the pre-edge values regardless of statement order.
            state_q      <= state_d;
            stage_q      <= stage_d;
            occ_q        <= occ_d;
            last_q       <= last_d;
            prev_q       <= cmp_i;
            wb_ack_o     <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
            trig_o       <= fire ? 32'h0000_0001 : 32'h0000_0000;
            storage_en_o <= storage_en_i & qual;
            data_o       <= data_i;
        end
    end

endmodule

// File: doc/diila_trig_seq.md
# diila_trig_seq

Programmable multi-stage trigger sequencer placed directly upstream of the integrated logic analyzer core.
- Watches a 32-bit compare word and walks up to four match stages, each with an occurrence count.
- On the final stage it emits the trigger code on `trig_o`, along with a storage qualifier and a data bus delayed to stay aligned.
- Outputs connect straight to the analyzer's `trig_i`, `storage_en` and `data_i`; the analyzer's trigger register is programmed to `32'h00000001`.
- Configured through its own Wishbone slave on the same bus clock.

## Interface
- `DATA_WIDTH`, default 96: width of the pass-through data bus; must match the analyzer core.
- `wb_clk_i` in 1: the only clock; all logic is on its rising edge.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wb_dat_i` in 32: write data.
- `wb_adr_i` in [23:2]: word address; only [7:2] is decoded.
- `wb_sel_i` in 4: ignored; every access is a full word.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i` in 1 each: standard Wishbone.
- `wb_dat_o` out 32: read data, combinational mux on `wb_adr_i`.
- `wb_ack_o` out 1: registered ack.
- `wb_err_o`, `wb_rty_o` out 1 each: tied to 0.
- `cmp_i` in 32: compare word evaluated by the stages and the qualifier.
- `storage_en_i` in 1: raw storage enable from the design.
- `data_i` in `DATA_WIDTH`: probe data.
- `trig_o` out 32: trigger code to the analyzer.
- `storage_en_o` out 1: qualified storage enable.
- `data_o` out `DATA_WIDTH`: `data_i` delayed 1 cycle.

## Operation

**Register map** (word index = `wb_adr_i[7:2]`):
- 0x00 CTRL (write-only actions):
  - bit0 ARM: start a new sequence; self-clearing.
  - bit1 ABORT: return to IDLE.
  - bits[5:4] LAST: index of the final stage.
- 0x01 STATUS (read-only): bit0 armed, bit1 fired, bits[5:4] current stage, bits[31:16] current occurrence count.
- 0x02 QMASK, 0x03 QVAL: qualifier mask and value.
- 0x04 QEN: bit0 enables the qualifier.
- Stage s = 0..3, four registers starting at 0x08+4s:
  - MASK(s), VAL(s), EDGE(s).
  - COUNT(s) in bits[15:0]; a value of 0 is treated as 1.
- Register readback: every config register reads back what was written. CTRL reads `{26'b0, LAST, 4'b0}`. Unmapped addresses read 0 and ignore writes.

**Bus behaviour**
- A write takes effect on any cycle where `stb & cyc & we` is high; it is not gated by ack, matching the analyzer core.
- `wb_ack_o` rises the cycle after `cyc & stb` and is high for exactly 1 cycle. It then stays low for 1 cycle before it can re-ack.

**Match and qualifier**
- `prev` is a register of `cmp_i` updated every cycle.
- `rise = cmp_i & ~prev`.
- `hit(s) = ((cmp_i ^ VAL(s)) & MASK(s)) == 0` and `(rise & EDGE(s)) == EDGE(s)`.
- MASK = 0 and EDGE = 0 means the stage hits every cycle.
- `qual = !QEN | (((cmp_i ^ QVAL) & QMASK) == 0)`.

**State machine** (state, stage[1:0], occ[15:0]):
- IDLE: entered on reset or ABORT. Outputs quiescent.
- ARMED: entered on an ARM write from any state. Clears stage and occ.
  - On `hit(stage)`: if `occ + 1 < max(COUNT(stage), 1)`, occ increments.
  - Otherwise, if `stage == LAST`, go to FIRED.
  - Otherwise stage increments and occ clears.
  - Only the current stage is evaluated; at most 1 stage advances per cycle.
- FIRED: holds until ARM or ABORT.
- LAST is sampled at ARM. Stage and count registers written while ARMED take effect on the next evaluation.
- Simultaneous ARM and ABORT in one write: ABORT wins, next state IDLE.

## Timing
- Reset values:
  - `wb_ack_o`, `trig_o`, `storage_en_o` and `data_o` are 0; `prev` is 0.
  - State IDLE; all config registers 0 (LAST = 0, QEN = 0).
- Pipeline: one registered stage; `cmp_i`, `storage_en_i` and `data_i` sampled at cycle t produce outputs at t+1.
- `trig_o` = `32'h00000001` for exactly 1 cycle: the cycle after the final hit that moves the state to FIRED. Otherwise it is 0.
- `data_o` at that cycle equals `data_i` of the final hit cycle.
- `storage_en_o(t+1) = storage_en_i(t) & qual(t)` in all states.
- ARM written at cycle t: `cmp_i` is first evaluated at t+1.
- A hit in the same cycle as an ARM write is ignored.
- COUNT = 0xFFFF needs 65535 hits; occ never wraps.
- Reset during ARMED: the next cycle is IDLE, `trig_o` is 0 and no pulse is emitted.

## Test plan
- Reset, then read every register:
  - All read 0.
  - `wb_ack_o` pulses 1 cycle per access.
  - `trig_o` stays 0 for 100 cycles with `cmp_i` random.
- Single stage, edge trigger:
  - Setup: LAST = 0, MASK0 = VAL0 = 0x0000FF00, EDGE0 = 0; ARM.
  - Stimulus: drive `cmp_i` = 0x00001200 for 5 cycles, then 0x0000FF00 at cycle k.
  - Check: `trig_o` = 1 only at k+1, and `data_o(k+1) = data_i(k)`.
  - Check: EDGE0 = 0x1 with `cmp_i[0]` held high never fires; toggling 0→1 fires.
- Sequence with counts:
  - Setup: LAST = 2; stage0 value 0xA needs COUNT 3, stage1 value 0xB, stage2 value 0xC.
  - Check: no fire until the third 0xA, then 0xB, then 0xC.
  - Check: STATUS shows stage 0→1→2 and then fired.
  - Check: an extra 0xC after firing produces no second pulse.
- Qualifier:
  - Setup: QEN = 1, QMASK = 0xF, QVAL = 0x5, `storage_en_i` = 1.
  - Check: `storage_en_o` is high exactly one cycle after each `cmp_i[3:0]` = 5.
  - Check: with QEN = 0, `storage_en_o` tracks `storage_en_i` delayed 1.
- Abort, re-arm and reset:
  - ABORT at stage 1: STATUS armed = 0, and the final match gives no fire.
  - ARM while FIRED restarts at stage 0.
  - `wb_rst_i` asserted mid-sequence: every output is 0 the next cycle.
  - Writing CTRL = 0x3: state IDLE.
